// File: rtl/pet_keys_pkg.sv
// pet_keys_pkg: shared FSM states, SHIFT key position and keymap entry type
package pet_keys_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_SHIFT, ST_PRESS, ST_RELEASE} state_t;
    localparam logic [3:0] SHIFT_ROW = 4'd8;
    localparam logic [2:0] SHIFT_COL = 3'd0;
    typedef struct packed {
        logic       valid;
        logic       shifted;
        logic [3:0] row;
        logic [2:0] col;
    } key_entry_t;
    function automatic key_entry_t key_at(input int row, input int col);
        return '{valid: 1'b1, shifted: 1'b0, row: 4'(row), col: 3'(col)};
    endfunction
endpackage

// File: rtl/pet_ascii_keymap.sv
// pet_ascii_keymap: ASCII byte to PET 2001 matrix position; uppercase letters need SHIFT
module pet_ascii_keymap
    import pet_keys_pkg::*;
(
    input  logic [7:0] ascii,
    output key_entry_t entry
);
    logic       upper;
    logic       lower;
    logic [7:0] ch;
    assign upper = ascii inside {[8'h41:8'h5A]};
    assign lower = ascii inside {[8'h61:8'h7A]};
    assign ch    = lower ? ascii - 8'h20 : ascii;
    always_comb begin
        entry = '0;
        case (ch)
            "!": entry = key_at(0, 0);   "#": entry = key_at(0, 1);   "%": entry = key_at(0, 2);
            "&": entry = key_at(0, 3);   "(": entry = key_at(0, 4);
            "\"": entry = key_at(1, 0);  "$": entry = key_at(1, 1);   "'": entry = key_at(1, 2);
            "\\": entry = key_at(1, 3);  ")": entry = key_at(1, 4);
            "Q": entry = key_at(2, 0);   "E": entry = key_at(2, 1);   "T": entry = key_at(2, 2);
            "U": entry = key_at(2, 3);   "O": entry = key_at(2, 4);   "^": entry = key_at(2, 5);
            "7": entry = key_at(2, 6);   "9": entry = key_at(2, 7);
            "W": entry = key_at(3, 0);   "R": entry = key_at(3, 1);   "Y": entry = key_at(3, 2);
            "I": entry = key_at(3, 3);   "P": entry = key_at(3, 4);   "8": entry = key_at(3, 6);
            "/": entry = key_at(3, 7);
            "A": entry = key_at(4, 0);   "D": entry = key_at(4, 1);   "G": entry = key_at(4, 2);
            "J": entry = key_at(4, 3);   "L": entry = key_at(4, 4);   "4": entry = key_at(4, 6);
            "6": entry = key_at(4, 7);
            "S": entry = key_at(5, 0);   "F": entry = key_at(5, 1);   "H": entry = key_at(5, 2);
            "K": entry = key_at(5, 3);   ":": entry = key_at(5, 4);   "5": entry = key_at(5, 6);
            "*": entry = key_at(5, 7);
            "Z": entry = key_at(6, 0);   "C": entry = key_at(6, 1);   "B": entry = key_at(6, 2);
            "M": entry = key_at(6, 3);   ";": entry = key_at(6, 4);   8'h0D: entry = key_at(6, 5);
            "1": entry = key_at(6, 6);   "3": entry = key_at(6, 7);
            "X": entry = key_at(7, 0);   "V": entry = key_at(7, 1);   "N": entry = key_at(7, 2);
            ",": entry = key_at(7, 3);   "?": entry = key_at(7, 4);   "2": entry = key_at(7, 6);
            "+": entry = key_at(7, 7);
            "@": entry = key_at(int'(SHIFT_ROW), 1);  "]": entry = key_at(int'(SHIFT_ROW), 2);
            ">": entry = key_at(int'(SHIFT_ROW), 4);  "0": entry = key_at(int'(SHIFT_ROW), 6);
            "-": entry = key_at(int'(SHIFT_ROW), 7);
            "[": entry = key_at(9, 1);   " ": entry = key_at(9, 2);   "<": entry = key_at(9, 3);
            ".": entry = key_at(9, 6);   "=": entry = key_at(9, 7);
            default: entry = '0;
        endcase
        entry.shifted = upper;
    end
endmodule

// File: rtl/pet_key_scheduler.sv
// pet_key_scheduler: buffers UART bytes and types them into the PET matrix with paced press/release
module pet_key_scheduler
    import pet_keys_pkg::*;
#(
    parameter int FIFO_AW     = 4,
    parameter int TICK_DIV    = 40000,
    parameter int HOLD_TICKS  = 40,
    parameter int GAP_TICKS   = 40,
    parameter int SHIFT_TICKS = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         uart_data,
    input  logic               uart_strobe,
    input  logic               pause,
    input  logic               clear_ovf,
    output logic [3:0]         key_row,
    output logic [2:0]         key_col,
    output logic               key_valid,
    output logic               shift_down,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);
    localparam int DEPTH     = 2 ** FIFO_AW;
    localparam int MAX_HG    = HOLD_TICKS > GAP_TICKS ? HOLD_TICKS : GAP_TICKS;
    localparam int MAX_TICKS = MAX_HG > SHIFT_TICKS ? MAX_HG : SHIFT_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam int PW        = $clog2(TICK_DIV);
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [7:0]         head;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic               tick;
    logic               done;
    logic [PW-1:0]      presc;
    logic [TW-1:0]      ticks;
    logic [TW-1:0]      last;
    state_t             state;
    state_t             state_n;
    key_entry_t         entry;
    pet_ascii_keymap u_keymap (
        .ascii (head),
        .entry (entry)
    );
    assign full = fifo_count == (FIFO_AW + 1)'(DEPTH);
    assign pop  = state == ST_IDLE && !pause && fifo_count != '0;
    assign push = uart_strobe && (!full || pop);
    assign drop = uart_strobe && full && !pop;
    assign tick = presc == PW'(TICK_DIV - 1);
    assign last = state == ST_SHIFT ? TW'(SHIFT_TICKS - 1) :
                  state == ST_PRESS ? TW'(HOLD_TICKS - 1) : TW'(GAP_TICKS - 1);
    assign done = tick && ticks == last;
    always_comb begin
        state_n = state;
        if (!pause)
            case (state)
                ST_IDLE:    state_n = fifo_count != '0 ? ST_LOOKUP : ST_IDLE;
                ST_LOOKUP:  state_n = !entry.valid ? ST_IDLE : entry.shifted ? ST_SHIFT : ST_PRESS;
                ST_SHIFT:   state_n = done ? ST_PRESS : ST_SHIFT;
                ST_PRESS:   state_n = done ? ST_RELEASE : ST_PRESS;
                ST_RELEASE: state_n = done ? ST_IDLE : ST_RELEASE;
                default:    state_n = ST_IDLE;
            endcase
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= uart_data;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            state      <= ST_IDLE;
            busy       <= 1'b0;
            presc      <= '0;
            ticks      <= '0;
            key_row    <= '0;
            key_col    <= '0;
            key_valid  <= 1'b0;
            shift_down <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + FIFO_AW'(push);
            rd_ptr     <= rd_ptr + FIFO_AW'(pop);
            fifo_count <= fifo_count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
            if (pop) head <= mem[rd_ptr];
            overflow   <= drop || (overflow && !clear_ovf);
            state      <= state_n;
            busy       <= state_n != ST_IDLE;
            // restarting the prescaler on each state change makes every timed state exact
            if (state_n != state) begin
                presc <= '0;
                ticks <= '0;
            end else if (!pause) begin
                presc <= tick ? '0 : presc + PW'(1);
                ticks <= ticks + TW'(tick);
            end
            if (!pause && state == ST_LOOKUP && entry.valid) begin
                key_row    <= entry.row;
                key_col    <= entry.col;
                key_valid  <= !entry.shifted;
                shift_down <= entry.shifted;
            end
            if (state == ST_SHIFT && state_n == ST_PRESS) key_valid <= 1'b1;
            if (state == ST_PRESS && state_n == ST_RELEASE) begin
                key_valid  <= 1'b0;
                shift_down <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pet_key_scheduler.sv
// tb_pet_key_scheduler: directed and randomized typing checked against a timeline model
module tb_pet_key_scheduler;
    localparam int D = 10;
    localparam int H = 3;
    localparam int G = 2;
    localparam int S = 1;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] uart_data = '0;
    logic       uart_strobe = 1'b0;
    logic       pause = 1'b0;
    logic       clear_ovf = 1'b0;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic       key_valid;
    logic       shift_down;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;
    int n_assert = 0;
    int n_fail = 0;
    string rows [10] = '{"!#%&(~~~", "\"$'\\)~~~", "QETUO^79", "WRYIP~8/", "ADGJL~46",
                         "SFHK:~5*", "ZCBM;\01513", "XVN,?~2+", "~@]~>~0-", "~[ <~~.="};
    always #5 clk = ~clk;
    pet_key_scheduler #(
        .FIFO_AW(4), .TICK_DIV(D), .HOLD_TICKS(H), .GAP_TICKS(G), .SHIFT_TICKS(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .uart_data(uart_data), .uart_strobe(uart_strobe),
        .pause(pause), .clear_ovf(clear_ovf), .key_row(key_row), .key_col(key_col),
        .key_valid(key_valid), .shift_down(shift_down), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask
    task automatic model(input logic [7:0] c, output bit mapped, output bit sh, output int r, output int col);
        logic [7:0] u;
        mapped = 0; r = 0; col = 0;
        u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
        sh = c >= "A" && c <= "Z";
        if (u == "~") return;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 8; j++)
                if (8'(rows[i][j]) == u) begin mapped = 1; r = i; col = j; end
        if (!mapped) sh = 0;
    endtask
    function automatic int shift_t(input int t, input int pa, input int pl);
        return (pl > 0 && t > pa) ? t + pl : t;
    endfunction
    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy && fifo_count == 0) break;
        end
        chk("idle_reached", {busy, fifo_count}, 0);
    endtask
    task automatic run_char(input logic [7:0] c, input int pa, input int pl, input int extra);
        bit mapped, sh;
        int r, col, budget;
        int e_kvr, e_kvf, e_sdr, e_sdf, e_bf;
        int kvr, kvf, sdr, sdf, bf, row_s, col_s, cnt_bf;
        logic kv_p, sd_p;
        bit seen_busy;
        kvr = -1; kvf = -1; sdr = -1; sdf = -1; bf = -1; row_s = -1; col_s = -1; cnt_bf = -1;
        kv_p = 0; sd_p = 0; seen_busy = 0;
        e_kvr = -1; e_kvf = -1; e_sdr = -1; e_sdf = -1;
        budget = 3 + (S + H + G) * D + pl + 20;
        wait_idle();
        model(c, mapped, sh, r, col);
        @(posedge clk); #1 uart_data = c; uart_strobe = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            pause = pl > 0 && k >= pa && k < pa + pl;
            uart_strobe = pl > 0 && k >= pa && k < pa + extra;
            uart_data = "1";
            @(negedge clk);
            if (key_valid && !kv_p && kvr < 0) begin kvr = k; row_s = key_row; col_s = key_col; end
            if (!key_valid && kv_p && kvf < 0) kvf = k;
            if (shift_down && !sd_p && sdr < 0) sdr = k;
            if (!shift_down && sd_p && sdf < 0) sdf = k;
            kv_p = key_valid; sd_p = shift_down;
            if (busy) seen_busy = 1;
            if (!busy && seen_busy) begin bf = k; cnt_bf = fifo_count; break; end
        end
        pause = 1'b0; uart_strobe = 1'b0;
        if (!mapped) e_bf = 3;
        else if (!sh) begin
            e_kvr = 3; e_kvf = 3 + H * D; e_bf = e_kvf + G * D;
        end else begin
            e_sdr = 3; e_kvr = 3 + S * D; e_kvf = e_kvr + H * D; e_sdf = e_kvf; e_bf = e_kvf + G * D;
        end
        chk($sformatf("kv_rise[%02h]", c), kvr, shift_t(e_kvr, pa, pl));
        chk($sformatf("kv_fall[%02h]", c), kvf, shift_t(e_kvf, pa, pl));
        chk($sformatf("sd_rise[%02h]", c), sdr, shift_t(e_sdr, pa, pl));
        chk($sformatf("sd_fall[%02h]", c), sdf, shift_t(e_sdf, pa, pl));
        chk($sformatf("busy_fall[%02h]", c), bf, shift_t(e_bf, pa, pl));
        chk($sformatf("count_at_idle[%02h]", c), cnt_bf, extra);
        if (mapped) begin
            chk($sformatf("row[%02h]", c), row_s, r);
            chk($sformatf("col[%02h]", c), col_s, col);
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
    initial begin
        int kvr4;
        bit sd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_shift_down", shift_down, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_row_col", {key_row, key_col}, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        run_char("a", 0, 0, 0);
        run_char("A", 0, 0, 0);
        run_char(8'h0D, 0, 0, 0);
        run_char(8'h0A, 0, 0, 0);
        wait_idle();
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1 uart_strobe = 1'b1; uart_data = 8'h61 + 8'(i);
        end
        @(posedge clk); #1 uart_strobe = 1'b0;
        @(negedge clk);
        chk("fill_count", fifo_count, 16);
        chk("fill_no_ovf", overflow, 0);
        @(posedge clk); #1 uart_strobe = 1'b1;
        @(posedge clk); #1 uart_strobe = 1'b0;
        @(negedge clk);
        chk("drop_ovf", overflow, 1);
        chk("drop_count", fifo_count, 16);
        @(posedge clk); #1 uart_strobe = 1'b1; clear_ovf = 1'b1;
        @(posedge clk); #1 uart_strobe = 1'b0; clear_ovf = 1'b0;
        @(negedge clk);
        chk("drop_beats_clear", overflow, 1);
        @(posedge clk); #1 clear_ovf = 1'b1;
        @(posedge clk); #1 clear_ovf = 1'b0;
        @(negedge clk);
        chk("clear_ovf", overflow, 0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("full_wait_idle", busy, 0);
        uart_strobe = 1'b1; uart_data = "z";
        @(posedge clk); #1 uart_strobe = 1'b0;
        @(negedge clk);
        chk("full_pop_push_count", fifo_count, 16);
        chk("full_pop_push_ovf", overflow, 0);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        wait_idle();
        @(posedge clk); #1 uart_data = 8'h0A; uart_strobe = 1'b1;
        kvr4 = -1; sd4 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1 uart_strobe = k == 1; uart_data = "a";
            @(negedge clk);
            if (key_valid && kvr4 < 0) kvr4 = k;
            if (shift_down) sd4 = 1;
        end
        chk("lf_then_a_rise", kvr4, 5);
        chk("lf_then_a_shift", sd4, 0);
        run_char("s", 10, 100, 2);
        wait_idle();
        @(posedge clk); #1 uart_data = "a"; uart_strobe = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1 uart_strobe = k == 1; uart_data = "b";
        end
        @(negedge clk);
        chk("pre_reset_kv", key_valid, 1);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_count", fifo_count, 1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("async_rst_kv", key_valid, 0);
        chk("async_rst_sd", shift_down, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_count", fifo_count, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        run_char("a", 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] c;
            int pa, pl;
            c = 8'($urandom_range(32, 126));
            if ($urandom_range(0, 2) == 0) begin
                pa = $urandom_range(1, 40);
                pl = $urandom_range(1, 20);
            end else begin
                pa = 0;
                pl = 0;
            end
            run_char(c, pa, pl, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
